// File: rtl/l293d_pwm_pkg.sv
// Shared types and control-word bit positions for the L293D PWM engine.
package l293d_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } ch_state_t;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_DIR = 1;
    localparam int unsigned CTRL_BRK = 2;
    localparam int unsigned CTRL_W   = 3;

endpackage

// File: rtl/l293d_pwm_channel.sv
// One H-bridge channel: period-aligned shadows, duty compare, dead-time FSM and
// registered bridge pins.
module l293d_pwm_channel
    import l293d_pwm_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEAD_CYC = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [CNT_W-1:0]  duty,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              wrap,
    input  logic              period_zero,
    output logic              pwm_en,
    output logic              in1,
    output logic              in2,
    output logic              dead
);

    localparam int unsigned DEAD_W = $clog2(DEAD_CYC + 1);

    ch_state_t         state, state_nx;
    logic [CNT_W-1:0]  duty_sh;
    logic              dir_sh, brake_sh, dir_app;
    logic [DEAD_W-1:0] dead_cnt;
    logic              enable, dir_live, pwm_raw;
    logic              en_nx, in1_nx, in2_nx, dead_nx;

    assign enable   = ctrl[CTRL_EN];
    // Direction as it will stand after this cycle's shadow load.
    assign dir_live = wrap ? ctrl[CTRL_DIR] : dir_sh;
    assign pwm_raw  = !period_zero && (cnt < duty_sh);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (wrap && enable) state_nx = RUN;
            RUN:  if (wrap && (ctrl[CTRL_DIR] != dir_app)) state_nx = DEAD;
            DEAD: if (dead_cnt == DEAD_W'(DEAD_CYC - 1)) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (!enable) state_nx = IDLE;
    end

    // Pins are gated by the raw enable so a drop clears them on the very next edge.
    always_comb begin
        en_nx   = 1'b0;
        in1_nx  = 1'b0;
        in2_nx  = 1'b0;
        dead_nx = 1'b0;
        if (enable) begin
            case (state)
                RUN: begin
                    en_nx  = brake_sh ? 1'b1 : pwm_raw;
                    in1_nx = !brake_sh && !dir_app;
                    in2_nx = !brake_sh && dir_app;
                end
                DEAD:    dead_nx = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_sh  <= '0;
            dir_sh   <= 1'b0;
            brake_sh <= 1'b0;
            dir_app  <= 1'b0;
            dead_cnt <= '0;
            pwm_en   <= 1'b0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            dead     <= 1'b0;
        end else begin
            state <= state_nx;
            if (wrap) begin
                duty_sh  <= duty;
                dir_sh   <= ctrl[CTRL_DIR];
                brake_sh <= ctrl[CTRL_BRK];
            end
            if (state != RUN && state_nx == RUN) dir_app <= dir_live;
            dead_cnt <= (state == DEAD && state_nx == DEAD) ? dead_cnt + DEAD_W'(1) : '0;
            pwm_en   <= en_nx;
            in1      <= in1_nx;
            in2      <= in2_nx;
            dead     <= dead_nx;
        end
    end

endmodule

// File: rtl/l293d_pwm_core.sv
// Three-channel L293D PWM engine: shared prescaler, period counter and wrap
// strobe feeding one channel instance per motor.
module l293d_pwm_core
    import l293d_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESC_W  = 16,
    parameter int unsigned DEAD_CYC = 100
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [CTRL_W*NUM_CH-1:0] ctrl_i,
    input  logic [PRESC_W-1:0]      presc_i,
    input  logic [CNT_W-1:0]        period_i,
    input  logic [CNT_W*NUM_CH-1:0] duty_i,
    output logic [NUM_CH-1:0]       pwm_en_o,
    output logic [NUM_CH-1:0]       in1_o,
    output logic [NUM_CH-1:0]       in2_o,
    output logic [NUM_CH-1:0]       dead_o,
    output logic                    period_stb_o
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   cnt;
    logic               tick, wrap, period_zero;

    assign tick        = (presc_cnt == presc_i);
    assign period_zero = (period_i == '0);
    assign wrap        = tick && !period_zero && (cnt >= period_i);

    // Using >= also pulls presc_cnt back to 0 when presc_i is lowered under it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            period_stb_o <= 1'b0;
        end else begin
            presc_cnt <= (presc_cnt >= presc_i) ? '0 : presc_cnt + PRESC_W'(1);
            if (period_zero)
                cnt <= '0;
            else if (tick)
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            period_stb_o <= wrap;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        l293d_pwm_channel #(
            .CNT_W    (CNT_W),
            .DEAD_CYC (DEAD_CYC)
        ) u_ch (
            .clk         (ACLK),
            .rst_n       (ARESETN),
            .ctrl        (ctrl_i[CTRL_W*c +: CTRL_W]),
            .duty        (duty_i[CNT_W*c +: CNT_W]),
            .cnt         (cnt),
            .wrap        (wrap),
            .period_zero (period_zero),
            .pwm_en      (pwm_en_o[c]),
            .in1         (in1_o[c]),
            .in2         (in2_o[c]),
            .dead        (dead_o[c])
        );
    end

endmodule
